// File: rtl/counter_ctrl_pkg.sv
// Shared constants, FSM encoding and direction helper for the counter move scheduler.
package counter_ctrl_pkg;

   localparam int CW_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      MOVE = 1'b1
   } state_e;

   // diff is (target - count) mod 2^cw; the upward path is shorter (or tied) when diff <= 2^(cw-1).
   function automatic logic shortest_up(input logic [15:0] diff, input int cw);
      return ({16'b0, diff} <= (32'd1 << (cw - 1)));
   endfunction

endpackage

// File: rtl/counter_move_sched_if.sv
// Requester handshake plus counter control/status bundle for counter_move_sched.
interface counter_move_sched_if #(
   parameter int NREQ = 2,
   parameter int CW   = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*CW-1:0] req_target;
   logic [NREQ-1:0]    req_ready;
   logic [CW-1:0]      cnt_count;
   logic               cnt_en;
   logic               cnt_up_down;
   logic               busy;
   logic               done;
   logic [IDW-1:0]     done_id;

   modport master (
      output req_valid, req_target, cnt_count,
      input  req_ready, cnt_en, cnt_up_down, busy, done, done_id
   );

   modport slave (
      input  req_valid, req_target, cnt_count,
      output req_ready, cnt_en, cnt_up_down, busy, done, done_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting after last_grant.
// last_grant moves only when the caller signals a completed transfer.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);
   logic [IDW-1:0] r_last;
   logic           w_found;

   // First pass covers ids above last_grant, second pass wraps to the low ids.
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      w_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req[i] && (i > int'(r_last))) begin
            w_found = 1'b1;
            gnt[i]  = 1'b1;
            gnt_id  = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req[i]) begin
            w_found = 1'b1;
            gnt[i]  = 1'b1;
            gnt_id  = IDW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= IDW'(NREQ - 1);
      end else if (advance) begin
         r_last <= gnt_id;
      end
   end
endmodule

// File: rtl/up_down_counter.sv
// Wrap-around up/down counter stepped by one whenever en is high.
module up_down_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          up_down,
   output logic [CW-1:0] count
);
   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= up_down ? r_count + CW'(1) : r_count - CW'(1);
      end
   end

   assign count = r_count;
endmodule

// File: rtl/counter_move_sched.sv
// Shares one up/down counter among NREQ requesters; a move of distance d ends with done d+1 cycles after transfer.
// req_ready is offered only in IDLE; requesters hold valid/target until granted.
module counter_move_sched
   import counter_ctrl_pkg::*;
#(
   parameter  int NREQ = 2,
   parameter  int CW   = CW_DEF,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   counter_move_sched_if.slave  bus
);
   state_e          r_state;
   state_e          w_state_nxt;
   logic [CW-1:0]   r_tgt;
   logic [IDW-1:0]  r_id;
   logic            r_done;
   logic [IDW-1:0]  r_done_id;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_gnt_id;
   logic            w_xfer;
   logic [CW-1:0]   w_diff;
   logic            w_at_tgt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.req_valid),
      .advance (w_xfer),
      .gnt     (w_gnt),
      .gnt_id  (w_gnt_id)
   );

   // Direction is re-evaluated from the live count so a disturbed counter still converges.
   assign w_diff   = r_tgt - bus.cnt_count;
   assign w_at_tgt = (w_diff == '0);

   always_comb begin
      w_state_nxt     = r_state;
      w_xfer          = 1'b0;
      bus.req_ready   = '0;
      bus.cnt_en      = 1'b0;
      bus.cnt_up_down = 1'b1;
      bus.busy        = 1'b0;
      case (r_state)
         IDLE: begin
            bus.req_ready = w_gnt;
            w_xfer        = |(bus.req_valid & w_gnt);
            if (w_xfer) w_state_nxt = MOVE;
         end
         MOVE: begin
            bus.busy        = 1'b1;
            bus.cnt_en      = !w_at_tgt;
            bus.cnt_up_down = shortest_up(16'(w_diff), CW);
            if (w_at_tgt) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_tgt     <= '0;
         r_id      <= '0;
         r_done    <= 1'b0;
         r_done_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == MOVE) && w_at_tgt;
         if (w_xfer) begin
            r_tgt <= bus.req_target[w_gnt_id*CW +: CW];
            r_id  <= w_gnt_id;
         end
         if ((r_state == MOVE) && w_at_tgt) r_done_id <= r_id;
      end
   end

   assign bus.done    = r_done;
   assign bus.done_id = r_done_id;
endmodule

// File: tb/tb_counter_move_sched.sv
// Directed bench: scheduler driving the real up_down_counter, with an offset to disturb the observed count.
module tb_counter_move_sched;
   localparam int NREQ = 2;
   localparam int CW   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] ctr_q;
   logic [CW-1:0] offset;
   logic [CW-1:0] exp_cnt;
   int            n_assert = 0;
   int            n_fail   = 0;
   int            n_done;

   counter_move_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

   counter_move_sched #(.NREQ(NREQ), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   up_down_counter #(.CW(CW)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.cnt_en),
      .up_down (bus.cnt_up_down),
      .count   (ctr_q)
   );

   assign bus.cnt_count = ctr_q + offset;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Post one request, then follow the move step by step with hand-given distance and direction.
   task automatic move(input int id, input logic [3:0] tgt, input int d, input logic up);
      bus.req_valid                = '0;
      bus.req_valid[id]            = 1'b1;
      bus.req_target[id*CW +: CW]  = tgt;
      #1;
      chk("grant", bus.req_ready, 32'd1 << id);
      @(negedge clk);
      bus.req_valid = '0;
      for (int i = 0; i < d; i++) begin
         chk("step_en", bus.cnt_en, 1);
         chk("step_dir", bus.cnt_up_down, up);
         chk("step_cnt", bus.cnt_count, exp_cnt);
         chk("step_busy", bus.busy, 1);
         chk("step_ready", bus.req_ready, 0);
         chk("step_nodone", bus.done, 0);
         exp_cnt = up ? exp_cnt + 4'd1 : exp_cnt - 4'd1;
         @(negedge clk);
      end
      chk("arrive_en", bus.cnt_en, 0);
      chk("arrive_cnt", bus.cnt_count, tgt);
      chk("arrive_nodone", bus.done, 0);
      @(negedge clk);
      chk("done", bus.done, 1);
      chk("done_id", bus.done_id, id);
      chk("done_busy", bus.busy, 0);
      chk("done_cnt_hold", bus.cnt_count, tgt);
   endtask

   initial begin
      rst            = 1'b1;
      offset         = '0;
      exp_cnt        = '0;
      bus.req_valid  = '0;
      bus.req_target = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_en", bus.cnt_en, 0);
      chk("rst_dir", bus.cnt_up_down, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_done_id", bus.done_id, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_cnt", bus.cnt_count, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready_none", bus.req_ready, 0);

      move(0, 4'd5, 5, 1'b1);
      move(1, 4'd14, 7, 1'b0);
      move(1, 4'd1, 3, 1'b1);
      move(0, 4'd0, 1, 1'b0);
      move(0, 4'd8, 8, 1'b1);
      move(0, 4'd9, 1, 1'b1);
      move(0, 4'd0, 7, 1'b1);
      move(1, 4'd3, 3, 1'b1);

      // Both requesters hold target 3 at count 3: zero-distance moves alternate 0,1,0,1.
      bus.req_valid  = 2'b11;
      bus.req_target = {4'd3, 4'd3};
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("alt_grant", bus.req_ready, 32'd1 << (g % 2));
         @(negedge clk);
         chk("alt_busy", bus.busy, 1);
         chk("alt_en", bus.cnt_en, 0);
         chk("alt_ready_off", bus.req_ready, 0);
         @(negedge clk);
         chk("alt_done", bus.done, 1);
         chk("alt_done_id", bus.done_id, g % 2);
      end
      bus.req_valid = '0;

      move(0, 4'd2, 1, 1'b0);

      // Reset two steps into a 2 -> 10 move.
      bus.req_valid       = 2'b10;
      bus.req_target[7:4] = 4'd10;
      #1;
      chk("rm_grant", bus.req_ready, 2'b10);
      @(negedge clk);
      bus.req_valid = '0;
      chk("rm_en", bus.cnt_en, 1);
      chk("rm_tie_up", bus.cnt_up_down, 1);
      repeat (2) @(negedge clk);
      chk("rm_cnt_before", bus.cnt_count, 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rm_en_off", bus.cnt_en, 0);
      chk("rm_busy_off", bus.busy, 0);
      chk("rm_no_done", bus.done, 0);
      chk("rm_cnt_zero", bus.cnt_count, 0);
      @(negedge clk);
      chk("rm_no_done2", bus.done, 0);
      chk("rm_idle", bus.busy, 0);
      bus.req_valid = 2'b11;
      #1;
      chk("rm_regrant0", bus.req_ready, 2'b01);

      // Disturbed move 0 -> 4: observed count jumps by 2 after the first step.
      bus.req_valid       = 2'b01;
      bus.req_target[3:0] = 4'd4;
      #1;
      chk("dist_grant", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = '0;
      chk("dist_en0", bus.cnt_en, 1);
      chk("dist_dir0", bus.cnt_up_down, 1);
      @(negedge clk);
      offset = 4'd2;
      #1;
      chk("dist_jump_cnt", bus.cnt_count, 3);
      chk("dist_en1", bus.cnt_en, 1);
      chk("dist_dir1", bus.cnt_up_down, 1);
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            n_done++;
            chk("dist_done_id", bus.done_id, 0);
         end
      end
      chk("dist_done_once", n_done, 1);
      chk("dist_final_cnt", bus.cnt_count, 4);
      chk("dist_idle", bus.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
